inst_enc: RTL and testbench

Sequential RV32I instruction encoder: the inverse of the immediate/field decode in the ID stage. Accepts format, register fields, function fields and a 32-bit immediate over a valid/ready handshake and packs them into a 32-bit instruction word. Each word is tagged with a running instruction-memory address and an immediate range-error flag, then buffered in a 2-entry output FIFO. Sits between the test/program-loader front end and the instruction-memory write port.

---
 rtl/inst_enc.sv | 133 +++++++++++++
 tb/tb_inst_enc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_enc.sv
// RV32I instruction encoder with running address tag and 2-entry output FIFO.
// Optional immediate range checking is built only when INST_ENC_RANGE_CHECK_EN is defined.
module inst_enc #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_LOAD  = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_LUI   = 3'd5;
  localparam logic [2:0] FMT_AUIPC = 3'd6;
  localparam logic [2:0] FMT_JAL   = 3'd7;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  localparam entry_t ENTRY_RST = '{inst: 32'h0, addr: BASE_ADDR, err: 1'b0};

  logic [31:0] enc;
  logic        err_c;
  logic [31:0] addr_cnt;
  logic [31:0] addr_eff;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        push;
  logic        pop;
  entry_t      slot0;
  entry_t      slot1;
  entry_t      new_entry;

  always_comb begin
    enc = 32'h0;
    case (in_fmt)
      FMT_R:     enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      FMT_I:     enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      FMT_LOAD:  enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      FMT_S:     enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      FMT_B:     enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      FMT_LUI:   enc = {in_imm[31:12], in_rd, 7'b0110111};
      FMT_AUIPC: enc = {in_imm[31:12], in_rd, 7'b0010111};
      FMT_JAL:   enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      default:   enc = 32'h0;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // A value fits a signed N-bit field when all bits above bit N-1 equal the sign bit.
  always_comb begin
    err_c = 1'b0;
    case (in_fmt)
      FMT_I, FMT_LOAD, FMT_S:
        err_c = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_B:
        err_c = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      FMT_JAL:
        err_c = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      FMT_LUI, FMT_AUIPC:
        err_c = |in_imm[11:0];
      default:
        err_c = 1'b0;
    endcase
  end
`else
  assign err_c = 1'b0;
`endif

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign addr_eff  = addr_load ? addr_val : addr_cnt;
  assign new_entry = '{inst: enc, addr: addr_eff, err: err_c};
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  // slot0 is always the head; entries shift forward on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
      slot0    <= ENTRY_RST;
      slot1    <= ENTRY_RST;
      addr_cnt <= BASE_ADDR;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (push) begin
        addr_cnt <= addr_eff + 32'd4;
      end else if (addr_load) begin
        addr_cnt <= addr_val;
      end
      if (pop && push) begin
        slot0 <= new_entry;
      end else if (pop) begin
        slot0 <= slot1;
      end else if (push) begin
        if (count == 2'd0) begin
          slot0 <= new_entry;
        end else begin
          slot1 <= new_entry;
        end
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_inst  = slot0.inst;
  assign out_addr  = slot0.addr;
  assign out_err   = slot0.err;

endmodule

// File: tb/tb_inst_enc.sv
// Self-checking bench for inst_enc: directed plan steps followed by randomized traffic
// compared against a queue-based reference model.
module tb_inst_enc;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  always #5 clk = ~clk;

  inst_enc #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_val(addr_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt;
  logic        m_rdy;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from field positions with shifts and masks.
  function automatic logic [31:0] m_enc(input logic [2:0] f, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (rs1 << 15) | (f3 << 12);
    case (f)
      3'd0: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 32'h33;
      3'd1: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | 32'h13;
      3'd2: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | 32'h03;
      3'd3: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | regs
                   | ((imm & 32'h1F) << 7) | 32'h23;
      3'd4: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (rs2 << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      3'd5: return (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
      3'd6: return (imm & 32'hFFFF_F000) | (rd << 7) | 32'h17;
      default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | 32'h6F;
    endcase
  endfunction

  function automatic logic m_err(input logic [2:0] f, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    if (!RC) return 1'b0;
    case (f)
      3'd1, 3'd2, 3'd3: return (s < -2048) || (s > 2047);
      3'd4: return (s < -4096) || (s > 4094) || (imm % 2 != 0);
      3'd7: return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || (imm % 2 != 0);
      3'd5, 3'd6: return (imm % 4096) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic req(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // Check outputs mid-cycle, advance the model, then step one clock.
  task automatic cycle();
    logic        push, pop;
    logic [31:0] aeff;
    ent_t        e;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    if (q.size() != 0) begin
      check("out_inst", out_inst, q[0].inst);
      check("out_addr", out_addr, q[0].addr);
      check("out_err", 32'(out_err), 32'(q[0].err));
    end
    push = in_valid && m_rdy;
    pop  = (q.size() != 0) && out_ready;
    aeff = addr_load ? addr_val : m_cnt;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.inst = m_enc(in_fmt, 32'(in_rd), 32'(in_rs1), 32'(in_rs2), 32'(in_funct3),
                     32'(in_funct7), in_imm);
      e.addr = aeff;
      e.err  = m_err(in_fmt, in_imm);
      q.push_back(e);
      m_cnt = aeff + 32'd4;
    end else if (addr_load) begin
      m_cnt = addr_val;
    end
    m_rdy = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_cnt = BASE;
    m_rdy = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_err", 32'(out_err), 32'h0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; addr_load = 1'b0; addr_val = '0;
    out_ready = 1'b1;
    q.delete(); m_cnt = BASE; m_rdy = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Basic encodings with consumer always ready.
    req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); cycle(); in_valid = 1'b0;
    check("i_inst", out_inst, 32'h0050_0093);
    check("i_addr", out_addr, BASE);
    check("i_err", 32'(out_err), 32'h0);
    req(3'd3, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -32'sd4); cycle();
    check("s_inst", out_inst, 32'hFE31_2E23);
    check("s_addr", out_addr, BASE + 32'd4);
    req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8); cycle(); in_valid = 1'b0;
    check("b_inst", out_inst, 32'hFE20_8CE3);
    check("b_addr", out_addr, BASE + 32'd8);
    req(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); cycle();
    check("jal_inst", out_inst, 32'h0010_00EF);
    req(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000); cycle(); in_valid = 1'b0;
    check("lui_inst", out_inst, 32'h1234_52B7);
    cycle();

    // Backpressure: third request is refused while full.
    out_ready = 1'b0;
    req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); cycle();
    req(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); cycle();
    req(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); cycle(); in_valid = 1'b0;
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_head", out_inst, 32'h0010_0113);
    cycle();
    check("full_head_stable", out_inst, 32'h0010_0113);
    out_ready = 1'b1; cycle();
    check("pop_in_ready", 32'(in_ready), 32'h1);
    check("pop_order", out_inst, 32'h0020_0193);
    cycle(); cycle();

    // Address load coincident with accept, then wrap.
    addr_load = 1'b1; addr_val = 32'hFFFF_FFFC;
    req(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0); cycle(); addr_load = 1'b0;
    check("load_addr", out_addr, 32'hFFFF_FFFC);
    req(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0); cycle(); in_valid = 1'b0;
    check("wrap_addr", out_addr, 32'h0000_0000);
    cycle();

    // Range-error flag.
    req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); cycle();
    check("err_i_2048", 32'(out_err), 32'(RC));
    req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6); cycle();
    check("err_b_6", 32'(out_err), 32'h0);
    req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7); cycle(); in_valid = 1'b0;
    check("err_b_7", 32'(out_err), 32'(RC));
    cycle();

    // Reset with buffered entries discards them.
    out_ready = 1'b0;
    req(3'd2, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'd16); cycle(); cycle();
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
        2: imm = 32'($signed($urandom_range(0, 16)) - 8 + (($urandom_range(0, 1) != 0) ? 2048 : -4096));
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      in_fmt    = 3'($urandom_range(0, 7));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = imm;
      out_ready = ($urandom_range(0, 9) < 6);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_val  = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
